scpad_dram_arbiter: RTL and testbench
=====================================

# scpad_dram_arbiter

Shares one DRAM request/response channel between `NUM_BE` scratchpad backends. Each backend sees a stall-based request port and a tagged response port. The block arbitrates backend DRAM requests round-robin into a one-entry output register and tags each request with the originating backend index. It limits outstanding reads per backend with credit counters, and routes DRAM read responses back through a one-entry response register. It sits between the backend array and the DRAM controller.

## Interface
Parameters:
- `NUM_BE`, 2: number of backends (power of two, ≥2).
- `ID_W`, 8: backend transaction id width.
- `ADDR_W`, 32: DRAM address width.
- `DATA_W`, 128: DRAM beat data width.
- `MASK_W`, 4: DRAM vector mask width.
- `MAX_OUTST`, 8: per-backend outstanding-read limit (≤255).

Ports (`TAG_W = $clog2(NUM_BE)`):
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous active-high reset.
- `be_req_valid`  in  NUM_BE  backend request valid.
- `be_req_write`  in  NUM_BE  1 = DRAM write.
- `be_req_id`  in  NUM_BE×ID_W  backend id.
- `be_req_addr`  in  NUM_BE×ADDR_W  DRAM address.
- `be_req_mask`  in  NUM_BE×MASK_W  vector mask.
- `be_req_wdata`  in  NUM_BE×DATA_W  write data.
- `be_req_stall`  out  NUM_BE  request not accepted this cycle.
- `be_res_valid`  out  NUM_BE  read response valid.
- `be_res_id`  out  ID_W  response id (shared bus).
- `be_res_rdata`  out  DATA_W  response data (shared bus).
- `be_res_stall`  in  NUM_BE  backend cannot take a response.
- `dram_req_valid`  out  1  request valid.
- `dram_req_ready`  in  1  DRAM accepts request.
- `dram_req_write`, `dram_req_addr`, `dram_req_mask`, `dram_req_wdata`  out  as above.
- `dram_req_id`  out  TAG_W+ID_W  `{be_index, be_id}`.
- `dram_res_valid`  in  1  read response valid.
- `dram_res_id`  in  TAG_W+ID_W  tagged id.
- `dram_res_rdata`  in  DATA_W  read data.
- `dram_res_ready`  out  1  response accepted.

## Operation
- Eligibility: backend i is eligible when `be_req_valid[i]` is high, and either it is a write or `credit[i] < MAX_OUTST`.
- Grant: at most one eligible backend per cycle. Search starts at `rr_ptr` and proceeds in ascending index order with wrap-around.
- Load condition: the output register loads when it is empty or draining (`dram_req_valid && dram_req_ready`) and a grant exists.
- Stall: `be_req_stall[i] = !(load && grant==i)`. This signal is combinational from the inputs. A stalled backend holds its request stable.
- Pointer update: on load, `rr_ptr <= grant+1` (mod `NUM_BE`). Otherwise `rr_ptr` is unchanged.
- Output register FSM:
  - EMPTY: goes to FULL on load.
  - FULL: stays FULL on drain+load or on no drain; goes to EMPTY on drain without load.
  - `dram_req_valid` = FULL. The payload is stable while `!dram_req_ready`.
- Credits: `credit[i]` increments on load of a read from i. It decrements when a response tagged i enters the response register. Increment and decrement in the same cycle leave it unchanged. It never exceeds `MAX_OUTST` and never underflows. A response arriving with zero credit is forwarded, and the counter saturates at 0.
- Response register: one entry holding tag, id, and data.
  - `dram_res_ready = !resp_full || !be_res_stall[resp_tag]`.
  - `be_res_valid[j] = resp_full && resp_tag==j`.
  - The entry drains when its target backend is not stalled. It can drain and reload in the same cycle.
- Writes produce no response and consume no credit.

## Timing
- Reset (async, all outputs): `dram_req_valid=0`, `dram_req_*` payload 0, `be_res_valid=0`, `be_res_id=0`, `be_res_rdata=0`, `dram_res_ready=1`, `be_req_stall` all 1 (for an empty register with no grant), `rr_ptr=0`, credits 0.
- Request latency: accepted at edge N, so `dram_req_valid` is high in cycle N+1. Sustained throughput is one request per cycle while `dram_req_ready` stays high.
- Response latency: `dram_res_valid && dram_res_ready` at edge N gives `be_res_valid` in cycle N+1.
- Reset mid-operation: in-flight register contents and credits are discarded. Responses to pre-reset requests are the system's responsibility.

## Configuration
- `SCPAD_DRAM_ARB_FIXED_PRIO_EN`:
  - When defined, the grant is the lowest eligible index and `rr_ptr` is unused (held at 0).
  - When undefined, round-robin applies as above.

## Test plan
- Single read: BE0 read, id 0x05, addr 0x100, `dram_req_ready`=1 -> next cycle `dram_req_valid`=1, `dram_req_id`={0,0x05}; response {0,0x05} -> `be_res_valid`=2'b01 next cycle, credit[0] returns to 0.
- Round-robin: BE0 and BE1 both requesting continuously, `NUM_BE`=2 -> DRAM ids alternate BE0, BE1, BE0, …; with the macro defined, BE0 only.
- Backpressure: `dram_req_ready`=0 for 5 cycles with BE1 requesting -> one request loaded; payload stable; `be_req_stall[1]`=1 for all 5 cycles.
- Credit limit: BE0 issues 8 reads with no responses -> 9th read stalled; BE1 read still granted; one BE0 response -> BE0 read granted next cycle.
- Response stall: `be_res_stall[1]`=1 with a response held for BE1 -> `dram_res_ready`=0; a second DRAM response waits; release -> drains 1/cycle.
- Reset mid-burst: assert `rst` with FULL register and credit[0]=3 -> immediately `dram_req_valid`=0 and credits 0.

Source files
------------

// File: rtl/scpad_dram_arbiter.sv
// scpad_dram_arbiter
// Shares one DRAM request/response channel between NUM_BE scratchpad backends.
// Requests are arbitrated into a one-entry output register and tagged with the
// backend index. Per-backend read credits bound outstanding reads. Read
// responses come back through a one-entry response register.
// Optional build macro: SCPAD_DRAM_ARB_FIXED_PRIO_EN selects fixed priority
// (lowest eligible index wins) instead of round-robin.
module scpad_dram_arbiter #(
    parameter int NUM_BE    = 2,
    parameter int ID_W      = 8,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 128,
    parameter int MASK_W    = 4,
    parameter int MAX_OUTST = 8,
    localparam int TAG_W    = $clog2(NUM_BE)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_BE-1:0]        be_req_valid,
    input  logic [NUM_BE-1:0]        be_req_write,
    input  logic [NUM_BE*ID_W-1:0]   be_req_id,
    input  logic [NUM_BE*ADDR_W-1:0] be_req_addr,
    input  logic [NUM_BE*MASK_W-1:0] be_req_mask,
    input  logic [NUM_BE*DATA_W-1:0] be_req_wdata,
    output logic [NUM_BE-1:0]        be_req_stall,
    output logic [NUM_BE-1:0]        be_res_valid,
    output logic [ID_W-1:0]          be_res_id,
    output logic [DATA_W-1:0]        be_res_rdata,
    input  logic [NUM_BE-1:0]        be_res_stall,
    output logic                     dram_req_valid,
    input  logic                     dram_req_ready,
    output logic                     dram_req_write,
    output logic [ADDR_W-1:0]        dram_req_addr,
    output logic [MASK_W-1:0]        dram_req_mask,
    output logic [DATA_W-1:0]        dram_req_wdata,
    output logic [TAG_W+ID_W-1:0]    dram_req_id,
    input  logic                     dram_res_valid,
    input  logic [TAG_W+ID_W-1:0]    dram_res_id,
    input  logic [DATA_W-1:0]        dram_res_rdata,
    output logic                     dram_res_ready
);

    // Credits are 8 bits wide; the outstanding limit never exceeds 255.
    localparam logic [7:0] MAX_CRED = 8'(MAX_OUTST);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } req_state_t;

    req_state_t                r_state;
    req_state_t                w_state_next;
    logic [TAG_W-1:0]          r_rr_ptr;
    logic [NUM_BE-1:0][7:0]    r_credit;

    logic                      r_req_write;
    logic [ADDR_W-1:0]         r_req_addr;
    logic [MASK_W-1:0]         r_req_mask;
    logic [DATA_W-1:0]         r_req_wdata;
    logic [TAG_W+ID_W-1:0]     r_req_id;

    logic                      r_resp_full;
    logic [TAG_W-1:0]          r_resp_tag;
    logic [ID_W-1:0]           r_resp_id;
    logic [DATA_W-1:0]         r_resp_data;

    logic [NUM_BE-1:0]         w_elig;
    logic [NUM_BE-1:0]         w_cred_inc;
    logic [NUM_BE-1:0]         w_cred_dec;
    logic                      w_grant_valid;
    logic [TAG_W-1:0]          w_grant;
    logic                      w_load;
    logic [TAG_W-1:0]          w_res_tag;
    logic                      w_resp_load;
    logic                      w_resp_drain;

    logic [ID_W-1:0]           w_id_arr    [NUM_BE];
    logic [ADDR_W-1:0]         w_addr_arr  [NUM_BE];
    logic [MASK_W-1:0]         w_mask_arr  [NUM_BE];
    logic [DATA_W-1:0]         w_wdata_arr [NUM_BE];

    // Per-backend slicing, eligibility, credit events, stall and response valid.
    generate
        for (genvar gi = 0; gi < NUM_BE; gi++) begin : g_be
            assign w_id_arr[gi]    = be_req_id[gi*ID_W +: ID_W];
            assign w_addr_arr[gi]  = be_req_addr[gi*ADDR_W +: ADDR_W];
            assign w_mask_arr[gi]  = be_req_mask[gi*MASK_W +: MASK_W];
            assign w_wdata_arr[gi] = be_req_wdata[gi*DATA_W +: DATA_W];
            assign w_elig[gi]      = be_req_valid[gi] &&
                                     (be_req_write[gi] || (r_credit[gi] < MAX_CRED));
            assign be_req_stall[gi] = !(w_load && (w_grant == TAG_W'(gi)));
            assign w_cred_inc[gi]  = w_load && (w_grant == TAG_W'(gi)) && !be_req_write[gi];
            assign w_cred_dec[gi]  = w_resp_load && (w_res_tag == TAG_W'(gi));
            assign be_res_valid[gi] = r_resp_full && (r_resp_tag == TAG_W'(gi));
        end
    endgenerate

    // Grant search: first eligible index at or after rr_ptr, wrapping. Scanning
    // from the far end lets the nearest hit overwrite earlier ones.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant       = '0;
        for (int k = NUM_BE - 1; k >= 0; k--) begin
            if (w_elig[r_rr_ptr + TAG_W'(k)]) begin
                w_grant_valid = 1'b1;
                w_grant       = r_rr_ptr + TAG_W'(k);
            end
        end
    end

    assign w_load = w_grant_valid && ((r_state == ST_EMPTY) || dram_req_ready);

    // Output register occupancy: next-state decision.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: if (w_load) w_state_next = ST_FULL;
            ST_FULL:  if (dram_req_ready && !w_load) w_state_next = ST_EMPTY;
            default:  w_state_next = ST_EMPTY;
        endcase
    end

    // Output register occupancy: state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_EMPTY;
        else     r_state <= w_state_next;
    end

    // Round-robin pointer moves past the winner; pinned at 0 for fixed priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_load) begin
`ifdef SCPAD_DRAM_ARB_FIXED_PRIO_EN
            r_rr_ptr <= '0;
`else
            r_rr_ptr <= w_grant + TAG_W'(1);
`endif
        end
    end

    // Request payload captured on load; held while the DRAM side is not ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_write <= 1'b0;
            r_req_addr  <= '0;
            r_req_mask  <= '0;
            r_req_wdata <= '0;
            r_req_id    <= '0;
        end else if (w_load) begin
            r_req_write <= be_req_write[w_grant];
            r_req_addr  <= w_addr_arr[w_grant];
            r_req_mask  <= w_mask_arr[w_grant];
            r_req_wdata <= w_wdata_arr[w_grant];
            r_req_id    <= {w_grant, w_id_arr[w_grant]};
        end
    end

    assign dram_req_valid = (r_state == ST_FULL);
    assign dram_req_write = r_req_write;
    assign dram_req_addr  = r_req_addr;
    assign dram_req_mask  = r_req_mask;
    assign dram_req_wdata = r_req_wdata;
    assign dram_req_id    = r_req_id;

    // Read credits: simultaneous issue and return cancel; saturate at both ends
    // so an unexpected response leaves the counter at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credit <= '0;
        end else begin
            for (int i = 0; i < NUM_BE; i++) begin
                if (w_cred_inc[i] && !w_cred_dec[i]) begin
                    if (r_credit[i] != MAX_CRED) r_credit[i] <= r_credit[i] + 8'd1;
                end else if (!w_cred_inc[i] && w_cred_dec[i]) begin
                    if (r_credit[i] != 8'd0) r_credit[i] <= r_credit[i] - 8'd1;
                end
            end
        end
    end

    assign w_res_tag      = dram_res_id[ID_W +: TAG_W];
    assign w_resp_drain   = r_resp_full && !be_res_stall[r_resp_tag];
    assign dram_res_ready = !r_resp_full || !be_res_stall[r_resp_tag];
    assign w_resp_load    = dram_res_valid && dram_res_ready;

    // Response register: reload takes priority over drain so both can happen
    // in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_full <= 1'b0;
            r_resp_tag  <= '0;
            r_resp_id   <= '0;
            r_resp_data <= '0;
        end else if (w_resp_load) begin
            r_resp_full <= 1'b1;
            r_resp_tag  <= w_res_tag;
            r_resp_id   <= dram_res_id[ID_W-1:0];
            r_resp_data <= dram_res_rdata;
        end else if (w_resp_drain) begin
            r_resp_full <= 1'b0;
        end
    end

    assign be_res_id    = r_resp_id;
    assign be_res_rdata = r_resp_data;

endmodule

// File: tb/tb_scpad_dram_arbiter.sv
// tb_scpad_dram_arbiter: directed tests for scpad_dram_arbiter (NUM_BE=2).
module tb_scpad_dram_arbiter;

    localparam int NUM_BE    = 2;
    localparam int ID_W      = 8;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 128;
    localparam int MASK_W    = 4;
    localparam int MAX_OUTST = 8;
    localparam int TAG_W     = 1;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_BE-1:0]        be_req_valid;
    logic [NUM_BE-1:0]        be_req_write;
    logic [NUM_BE*ID_W-1:0]   be_req_id;
    logic [NUM_BE*ADDR_W-1:0] be_req_addr;
    logic [NUM_BE*MASK_W-1:0] be_req_mask;
    logic [NUM_BE*DATA_W-1:0] be_req_wdata;
    logic [NUM_BE-1:0]        be_req_stall;
    logic [NUM_BE-1:0]        be_res_valid;
    logic [ID_W-1:0]          be_res_id;
    logic [DATA_W-1:0]        be_res_rdata;
    logic [NUM_BE-1:0]        be_res_stall;
    logic                     dram_req_valid;
    logic                     dram_req_ready;
    logic                     dram_req_write;
    logic [ADDR_W-1:0]        dram_req_addr;
    logic [MASK_W-1:0]        dram_req_mask;
    logic [DATA_W-1:0]        dram_req_wdata;
    logic [TAG_W+ID_W-1:0]    dram_req_id;
    logic                     dram_res_valid;
    logic [TAG_W+ID_W-1:0]    dram_res_id;
    logic [DATA_W-1:0]        dram_res_rdata;
    logic                     dram_res_ready;

    int n_checks = 0;
    int n_pass   = 0;

    scpad_dram_arbiter #(
        .NUM_BE(NUM_BE), .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .MASK_W(MASK_W), .MAX_OUTST(MAX_OUTST)
    ) dut (
        .clk(clk), .rst(rst),
        .be_req_valid(be_req_valid), .be_req_write(be_req_write),
        .be_req_id(be_req_id), .be_req_addr(be_req_addr),
        .be_req_mask(be_req_mask), .be_req_wdata(be_req_wdata),
        .be_req_stall(be_req_stall),
        .be_res_valid(be_res_valid), .be_res_id(be_res_id),
        .be_res_rdata(be_res_rdata), .be_res_stall(be_res_stall),
        .dram_req_valid(dram_req_valid), .dram_req_ready(dram_req_ready),
        .dram_req_write(dram_req_write), .dram_req_addr(dram_req_addr),
        .dram_req_mask(dram_req_mask), .dram_req_wdata(dram_req_wdata),
        .dram_req_id(dram_req_id),
        .dram_res_valid(dram_res_valid), .dram_res_id(dram_res_id),
        .dram_res_rdata(dram_res_rdata), .dram_res_ready(dram_res_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %s = %0h", tag, got);
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [DATA_W-1:0] d_a, d_b, d_c, w_a, w_b;
    int g;

    initial begin
        d_a = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
        d_b = 128'hdead_beef_cafe_f00d_1111_2222_3333_4444;
        d_c = 128'h5555_aaaa_5555_aaaa_0f0f_f0f0_1234_5678;
        w_a = 128'h7777_8888_9999_aaaa_bbbb_cccc_dddd_eeee;
        w_b = 128'h0000_0001_0000_0002_0000_0003_0000_0004;

        rst = 1'b1;
        be_req_valid = '0; be_req_write = '0; be_req_id = '0; be_req_addr = '0;
        be_req_mask = '0; be_req_wdata = '0; be_res_stall = '0;
        dram_req_ready = 1'b0; dram_res_valid = 1'b0; dram_res_id = '0; dram_res_rdata = '0;

        // Reset state
        #3;
        chk("rst_req_valid", dram_req_valid, 0);
        chk("rst_req_id", dram_req_id, 0);
        chk("rst_req_addr", dram_req_addr, 0);
        chk("rst_res_ready", dram_res_ready, 1);
        chk("rst_stall", be_req_stall, 2'b11);
        chk("rst_res_valid", be_res_valid, 0);
        chk("rst_res_id", be_res_id, 0);
        chk("rst_res_rdata", be_res_rdata, 0);
        #9 rst = 1'b0;
        step();

        // Single read from BE0
        be_req_valid = 2'b01; be_req_write = 2'b00;
        be_req_id[7:0] = 8'h05; be_req_addr[31:0] = 32'h100;
        dram_req_ready = 1'b1;
        #1 chk("t1_stall", be_req_stall, 2'b10);
        step();
        be_req_valid = 2'b00;
        chk("t1_req_valid", dram_req_valid, 1);
        chk("t1_req_id", dram_req_id, 9'h005);
        chk("t1_req_addr", dram_req_addr, 32'h100);
        chk("t1_req_write", dram_req_write, 0);
        chk("t1_credit0_up", dut.r_credit[0], 1);
        step();
        chk("t1_req_drained", dram_req_valid, 0);
        dram_res_valid = 1'b1; dram_res_id = 9'h005; dram_res_rdata = d_a;
        #1 chk("t1_res_ready", dram_res_ready, 1);
        step();
        dram_res_valid = 1'b0;
        chk("t1_be_res_valid", be_res_valid, 2'b01);
        chk("t1_be_res_id", be_res_id, 8'h05);
        chk("t1_be_res_rdata", be_res_rdata, d_a);
        chk("t1_credit0_back", dut.r_credit[0], 0);
        step();
        chk("t1_res_drained", be_res_valid, 0);

        // Round-robin with both backends writing continuously
        be_req_valid = 2'b11; be_req_write = 2'b11;
        be_req_id[7:0] = 8'h10; be_req_id[15:8] = 8'h20;
        #1;
        for (int k = 0; k < 4; k++) begin
`ifdef SCPAD_DRAM_ARB_FIXED_PRIO_EN
            g = 0;
`else
            g = (1 + k) % 2;
`endif
            chk($sformatf("t2_stall_%0d", k), be_req_stall, (g == 0) ? 2'b10 : 2'b01);
            step();
            chk($sformatf("t2_req_id_%0d", k), dram_req_id,
                (g == 0) ? 9'h010 : 9'h120);
        end
        chk("t2_req_write", dram_req_write, 1);
        chk("t2_no_credit", dut.r_credit[0], 0);
        be_req_valid = 2'b00;
        step();

        // Backpressure with BE1 writing
        dram_req_ready = 1'b0;
        be_req_valid = 2'b10; be_req_write = 2'b10;
        be_req_id[15:8] = 8'h33; be_req_addr[63:32] = 32'h2000;
        be_req_mask[7:4] = 4'ha; be_req_wdata[255:128] = w_a;
        #1 chk("t3_first_stall", be_req_stall, 2'b01);
        step();
        be_req_id[15:8] = 8'h34; be_req_addr[63:32] = 32'h3000;
        be_req_mask[7:4] = 4'h5; be_req_wdata[255:128] = w_b;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t3_stall1_%0d", k), be_req_stall[1], 1);
            chk($sformatf("t3_hold_id_%0d", k), dram_req_id, 9'h133);
            chk($sformatf("t3_hold_addr_%0d", k), dram_req_addr, 32'h2000);
            step();
        end
        chk("t3_hold_mask", dram_req_mask, 4'ha);
        chk("t3_hold_wdata", dram_req_wdata, w_a);
        dram_req_ready = 1'b1;
        #1 chk("t3_release_stall", be_req_stall, 2'b01);
        step();
        be_req_valid = 2'b00;
        chk("t3_next_id", dram_req_id, 9'h134);
        chk("t3_next_wdata", dram_req_wdata, w_b);
        chk("t3_no_credit1", dut.r_credit[1], 0);
        step();

        // Credit limit on BE0 reads
        be_req_valid = 2'b01; be_req_write = 2'b00;
        for (int k = 0; k < 8; k++) begin
            be_req_id[7:0] = 8'(k);
            #1 chk($sformatf("t4_issue_%0d", k), be_req_stall[0], 0);
            step();
        end
        chk("t4_last_id", dram_req_id, 9'h007);
        chk("t4_credit0_max", dut.r_credit[0], 8);
        be_req_id[7:0] = 8'h08;
        be_req_valid = 2'b11; be_req_id[15:8] = 8'h40;
        #1 chk("t4_be1_granted", be_req_stall, 2'b01);
        step();
        be_req_valid = 2'b01;
        chk("t4_be1_id", dram_req_id, 9'h140);
        chk("t4_credit1", dut.r_credit[1], 1);
        dram_res_valid = 1'b1; dram_res_id = 9'h000; dram_res_rdata = d_b;
        #1 chk("t4_be0_blocked", be_req_stall[0], 1);
        step();
        dram_res_valid = 1'b0;
        chk("t4_credit0_ret", dut.r_credit[0], 7);
        chk("t4_res_valid", be_res_valid, 2'b01);
        chk("t4_be0_granted", be_req_stall[0], 0);
        step();
        be_req_valid = 2'b00;
        chk("t4_ninth_id", dram_req_id, 9'h008);
        chk("t4_credit0_refill", dut.r_credit[0], 8);

        // Response stall toward BE1
        be_res_stall = 2'b10;
        dram_res_valid = 1'b1; dram_res_id = 9'h140; dram_res_rdata = d_c;
        #1 chk("t5_ready_empty", dram_res_ready, 1);
        step();
        dram_res_id = 9'h141; dram_res_rdata = d_a;
        chk("t5_held_valid", be_res_valid, 2'b10);
        chk("t5_held_id", be_res_id, 8'h40);
        chk("t5_ready_blocked", dram_res_ready, 0);
        chk("t5_credit1_zero", dut.r_credit[1], 0);
        step();
        chk("t5_still_id", be_res_id, 8'h40);
        chk("t5_still_data", be_res_rdata, d_c);
        chk("t5_still_blocked", dram_res_ready, 0);
        be_res_stall = 2'b00;
        #1 chk("t5_ready_release", dram_res_ready, 1);
        step();
        dram_res_valid = 1'b0;
        chk("t5_second_valid", be_res_valid, 2'b10);
        chk("t5_second_id", be_res_id, 8'h41);
        chk("t5_second_data", be_res_rdata, d_a);
        chk("t5_credit1_sat", dut.r_credit[1], 0);
        step();
        chk("t5_drained", be_res_valid, 0);

        // Bring credit[0] to 3 with a full request register, then reset
        dram_res_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            dram_res_id = 9'(k);
            step();
        end
        dram_res_valid = 1'b0;
        chk("t6_credit0_two", dut.r_credit[0], 2);
        dram_req_ready = 1'b0;
        be_req_valid = 2'b01; be_req_id[7:0] = 8'h09;
        step();
        be_req_valid = 2'b00;
        chk("t6_full", dram_req_valid, 1);
        chk("t6_credit0_three", dut.r_credit[0], 3);
        rst = 1'b1;
        #1;
        chk("t6_rst_req_valid", dram_req_valid, 0);
        chk("t6_rst_credit0", dut.r_credit[0], 0);
        chk("t6_rst_req_id", dram_req_id, 0);
        chk("t6_rst_stall", be_req_stall, 2'b11);
        chk("t6_rst_res_valid", be_res_valid, 0);
        #1 rst = 1'b0;
        step();
        chk("t6_post_rst_valid", dram_req_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
